// File: rtl/tlb_sweep_if.sv
// tlb_sweep_if: search, read, write/fill and INVTLB channels of the tlb_sweep TLB.
// master drives requests (translation stage / TLB-instruction unit), slave is the TLB.
interface tlb_sweep_if #(
   parameter int unsigned TLBNUM = 16,
   parameter int unsigned ASID_W = 10
);
   localparam int unsigned IDXW = $clog2(TLBNUM);

   // search port
   logic              s_req;
   logic [18:0]       s_vppn;
   logic              s_va_bit12;
   logic [ASID_W-1:0] s_asid;
   logic              s_resp;
   logic              s_found;
   logic [IDXW-1:0]   s_index;
   logic [19:0]       s_ppn;
   logic [5:0]        s_ps;
   logic [1:0]        s_plv;
   logic [1:0]        s_mat;
   logic              s_d;
   logic              s_v;

   // read port
   logic              r_req;
   logic [IDXW-1:0]   r_index;
   logic              r_resp;
   logic              r_e;
   logic [18:0]       r_vppn;
   logic [5:0]        r_ps;
   logic [ASID_W-1:0] r_asid;
   logic              r_g;
   logic [19:0]       r_ppn0;
   logic [1:0]        r_plv0;
   logic [1:0]        r_mat0;
   logic              r_d0;
   logic              r_v0;
   logic [19:0]       r_ppn1;
   logic [1:0]        r_plv1;
   logic [1:0]        r_mat1;
   logic              r_d1;
   logic              r_v1;

   // write / fill port
   logic              we;
   logic              w_fill;
   logic [IDXW-1:0]   w_index;
   logic              w_e;
   logic [18:0]       w_vppn;
   logic [5:0]        w_ps;
   logic [ASID_W-1:0] w_asid;
   logic              w_g;
   logic [19:0]       w_ppn0;
   logic [1:0]        w_plv0;
   logic [1:0]        w_mat0;
   logic              w_d0;
   logic              w_v0;
   logic [19:0]       w_ppn1;
   logic [1:0]        w_plv1;
   logic [1:0]        w_mat1;
   logic              w_d1;
   logic              w_v1;
   logic              w_ready;
   logic [IDXW-1:0]   fill_index;

   // INVTLB port
   logic              inv_valid;
   logic [4:0]        inv_op;
   logic [ASID_W-1:0] inv_asid;
   logic [18:0]       inv_vppn;
   logic              inv_ready;
   logic              inv_done;
   logic              inv_err;

   modport master (
      output s_req, s_vppn, s_va_bit12, s_asid,
      input  s_resp, s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v,
      output r_req, r_index,
      input  r_resp, r_e, r_vppn, r_ps, r_asid, r_g,
      input  r_ppn0, r_plv0, r_mat0, r_d0, r_v0, r_ppn1, r_plv1, r_mat1, r_d1, r_v1,
      output we, w_fill, w_index, w_e, w_vppn, w_ps, w_asid, w_g,
      output w_ppn0, w_plv0, w_mat0, w_d0, w_v0, w_ppn1, w_plv1, w_mat1, w_d1, w_v1,
      input  w_ready, fill_index,
      output inv_valid, inv_op, inv_asid, inv_vppn,
      input  inv_ready, inv_done, inv_err
   );

   modport slave (
      input  s_req, s_vppn, s_va_bit12, s_asid,
      output s_resp, s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v,
      input  r_req, r_index,
      output r_resp, r_e, r_vppn, r_ps, r_asid, r_g,
      output r_ppn0, r_plv0, r_mat0, r_d0, r_v0, r_ppn1, r_plv1, r_mat1, r_d1, r_v1,
      input  we, w_fill, w_index, w_e, w_vppn, w_ps, w_asid, w_g,
      input  w_ppn0, w_plv0, w_mat0, w_d0, w_v0, w_ppn1, w_plv1, w_mat1, w_d1, w_v1,
      output w_ready, fill_index,
      input  inv_valid, inv_op, inv_asid, inv_vppn,
      output inv_ready, inv_done, inv_err
   );
endinterface

// File: rtl/tlb_sweep.sv
// tlb_sweep: fully associative TLB with registered search/read ports, free-first/LFSR fill
// and a one-entry-per-cycle INVTLB sweep engine.
// Optional feature macro TLB_PERF_EN: adds saturating perf_hit/perf_miss search counters.
module tlb_sweep #(
   parameter int unsigned TLBNUM = 16,
   parameter int unsigned ASID_W = 10
) (
   input logic        clk,
   input logic        resetn,
   tlb_sweep_if.slave bus
`ifdef TLB_PERF_EN
   ,
   output logic [31:0] perf_hit,
   output logic [31:0] perf_miss
`endif
);
   localparam int unsigned IDXW = $clog2(TLBNUM);

   typedef struct packed {
      logic [19:0] ppn;
      logic [1:0]  plv;
      logic [1:0]  mat;
      logic        d;
      logic        v;
   } page_t;

   typedef struct packed {
      logic [18:0]       vppn;
      logic [5:0]        ps;
      logic [ASID_W-1:0] asid;
      logic              g;
      page_t             p0;
      page_t             p1;
   } ent_t;

   typedef struct packed {
      logic            found;
      logic [IDXW-1:0] index;
      page_t           pg;
      logic [5:0]      ps;
   } s_res_t;

   typedef struct packed {
      logic e;
      ent_t ent;
   } r_res_t;

   typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

   // 4 MB pages compare only VA[31:22]; 4 KB pages compare the full VPPN.
   function automatic logic va_match(logic [18:0] ev, logic [5:0] ps, logic [18:0] v);
      return (ps == 6'd21) ? (ev[18:9] == v[18:9]) : (ev == v);
   endfunction

   logic [TLBNUM-1:0] tlb_e_q, tlb_e_d;
   ent_t              tlb_q [TLBNUM];

   state_e            state_q, state_d;
   logic [IDXW-1:0]   ptr_q, ptr_d;
   logic [4:0]        op_q, op_d;
   logic [ASID_W-1:0] inv_asid_q, inv_asid_d;
   logic [18:0]       inv_vppn_q, inv_vppn_d;
   logic              inv_done_q, inv_done_d;
   logic              inv_err_q, inv_err_d;
   logic              ready_q, ready_d;

   logic [15:0]       lfsr_q, lfsr_d;
   logic [IDXW-1:0]   fill_index_q, fill_index_d;
   s_res_t            s_res_q, s_res_d;
   logic              s_resp_q;
   r_res_t            r_res_q, r_res_d;
   logic              r_resp_q;

   logic              s_hit;
   logic [IDXW-1:0]   s_hit_idx;
   ent_t              s_ent;
   logic              s_odd;
   logic              free_any;
   logic [IDXW-1:0]   free_idx;
   logic [IDXW-1:0]   w_tgt;
   logic              w_go;
   ent_t              w_ent;
   ent_t              c_ent;
   logic              c_clr;

   // Search hit vector reduced to the lowest matching index.
   always_comb begin
      s_hit     = 1'b0;
      s_hit_idx = '0;
      for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
         if (tlb_e_q[i] && (tlb_q[i].g || (tlb_q[i].asid == bus.s_asid)) &&
             va_match(tlb_q[i].vppn, tlb_q[i].ps, bus.s_vppn)) begin
            s_hit     = 1'b1;
            s_hit_idx = IDXW'(i);
         end
      end
   end

   // Next search/read result; holds when no request is presented.
   always_comb begin
      s_ent   = tlb_q[s_hit_idx];
      s_odd   = (s_ent.ps == 6'd21) ? bus.s_vppn[8] : bus.s_va_bit12;
      s_res_d = s_res_q;
      if (bus.s_req) begin
         s_res_d = '0;
         if (s_hit) begin
            s_res_d.found = 1'b1;
            s_res_d.index = s_hit_idx;
            s_res_d.pg    = s_odd ? s_ent.p1 : s_ent.p0;
            s_res_d.ps    = s_ent.ps;
         end
      end
      r_res_d = r_res_q;
      if (bus.r_req) begin
         r_res_d.e   = tlb_e_q[bus.r_index];
         r_res_d.ent = tlb_q[bus.r_index];
      end
   end

   // Lowest free entry for fills; LFSR victim when the table is full.
   always_comb begin
      free_any = 1'b0;
      free_idx = '0;
      for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
         if (!tlb_e_q[i]) begin
            free_any = 1'b1;
            free_idx = IDXW'(i);
         end
      end
      w_go         = bus.we && (state_q == StIdle);
      w_tgt        = bus.w_fill ? (free_any ? free_idx : lfsr_q[IDXW-1:0]) : bus.w_index;
      fill_index_d = (w_go && bus.w_fill) ? w_tgt : fill_index_q;
      lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      w_ent.vppn   = bus.w_vppn;
      w_ent.ps     = bus.w_ps;
      w_ent.asid   = bus.w_asid;
      w_ent.g      = bus.w_g;
      w_ent.p0     = '{ppn: bus.w_ppn0, plv: bus.w_plv0, mat: bus.w_mat0, d: bus.w_d0,
                       v: bus.w_v0};
      w_ent.p1     = '{ppn: bus.w_ppn1, plv: bus.w_plv1, mat: bus.w_mat1, d: bus.w_d1,
                       v: bus.w_v1};
   end

   // INVTLB qualification of the entry under the sweep pointer.
   always_comb begin
      c_ent = tlb_q[ptr_q];
      c_clr = 1'b0;
      case (op_q)
         5'd0, 5'd1: c_clr = 1'b1;
         5'd2:       c_clr = c_ent.g;
         5'd3:       c_clr = !c_ent.g;
         5'd4:       c_clr = !c_ent.g && (c_ent.asid == inv_asid_q);
         5'd5:       c_clr = !c_ent.g && (c_ent.asid == inv_asid_q) &&
                             va_match(c_ent.vppn, c_ent.ps, inv_vppn_q);
         5'd6:       c_clr = (c_ent.g || (c_ent.asid == inv_asid_q)) &&
                             va_match(c_ent.vppn, c_ent.ps, inv_vppn_q);
         default:    c_clr = 1'b0;
      endcase
      tlb_e_d = tlb_e_q;
      if (state_q == StSweep && c_clr) begin
         tlb_e_d[ptr_q] = 1'b0;
      end
      if (w_go) begin
         tlb_e_d[w_tgt] = bus.w_e;
      end
   end

   // Sweep FSM next state; a write in the same IDLE cycle wins over INVTLB.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      op_d       = op_q;
      inv_asid_d = inv_asid_q;
      inv_vppn_d = inv_vppn_q;
      inv_done_d = 1'b0;
      inv_err_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.inv_valid && !bus.we) begin
               if (bus.inv_op <= 5'd6) begin
                  op_d       = bus.inv_op;
                  inv_asid_d = bus.inv_asid;
                  inv_vppn_d = bus.inv_vppn;
                  ptr_d      = '0;
                  state_d    = StSweep;
               end else begin
                  inv_err_d = 1'b1;
               end
            end
         end
         StSweep: begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == IDXW'(TLBNUM - 1)) begin
               state_d    = StDone;
               inv_done_d = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      ready_d = (state_d == StIdle);
   end

   // FSM state and its registered handshake outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         op_q       <= '0;
         inv_asid_q <= '0;
         inv_vppn_q <= '0;
         inv_done_q <= 1'b0;
         inv_err_q  <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         op_q       <= op_d;
         inv_asid_q <= inv_asid_d;
         inv_vppn_q <= inv_vppn_d;
         inv_done_q <= inv_done_d;
         inv_err_q  <= inv_err_d;
         ready_q    <= ready_d;
      end
   end

   // Valid bits, LFSR and registered port results.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tlb_e_q      <= '0;
         lfsr_q       <= 16'hACE1;
         fill_index_q <= '0;
         s_res_q      <= '0;
         s_resp_q     <= 1'b0;
         r_res_q      <= '0;
         r_resp_q     <= 1'b0;
      end else begin
         tlb_e_q      <= tlb_e_d;
         lfsr_q       <= lfsr_d;
         fill_index_q <= fill_index_d;
         s_res_q      <= s_res_d;
         s_resp_q     <= bus.s_req;
         r_res_q      <= r_res_d;
         r_resp_q     <= bus.r_req;
      end
   end

   // Entry payload is deliberately not reset; only the valid bits are.
   always_ff @(posedge clk) begin
      if (w_go) begin
         tlb_q[w_tgt] <= w_ent;
      end
   end

`ifdef TLB_PERF_EN
   logic [31:0] perf_hit_q, perf_hit_d;
   logic [31:0] perf_miss_q, perf_miss_d;

   // Saturating hit/miss counts, one step per search request.
   always_comb begin
      perf_hit_d  = perf_hit_q;
      perf_miss_d = perf_miss_q;
      if (bus.s_req) begin
         if (s_hit && (perf_hit_q != 32'hFFFF_FFFF)) begin
            perf_hit_d = perf_hit_q + 32'd1;
         end
         if (!s_hit && (perf_miss_q != 32'hFFFF_FFFF)) begin
            perf_miss_d = perf_miss_q + 32'd1;
         end
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         perf_hit_q  <= '0;
         perf_miss_q <= '0;
      end else begin
         perf_hit_q  <= perf_hit_d;
         perf_miss_q <= perf_miss_d;
      end
   end

   assign perf_hit  = perf_hit_q;
   assign perf_miss = perf_miss_q;
`endif

   assign bus.s_resp     = s_resp_q;
   assign bus.s_found    = s_res_q.found;
   assign bus.s_index    = s_res_q.index;
   assign bus.s_ppn      = s_res_q.pg.ppn;
   assign bus.s_ps       = s_res_q.ps;
   assign bus.s_plv      = s_res_q.pg.plv;
   assign bus.s_mat      = s_res_q.pg.mat;
   assign bus.s_d        = s_res_q.pg.d;
   assign bus.s_v        = s_res_q.pg.v;

   assign bus.r_resp     = r_resp_q;
   assign bus.r_e        = r_res_q.e;
   assign bus.r_vppn     = r_res_q.ent.vppn;
   assign bus.r_ps       = r_res_q.ent.ps;
   assign bus.r_asid     = r_res_q.ent.asid;
   assign bus.r_g        = r_res_q.ent.g;
   assign bus.r_ppn0     = r_res_q.ent.p0.ppn;
   assign bus.r_plv0     = r_res_q.ent.p0.plv;
   assign bus.r_mat0     = r_res_q.ent.p0.mat;
   assign bus.r_d0       = r_res_q.ent.p0.d;
   assign bus.r_v0       = r_res_q.ent.p0.v;
   assign bus.r_ppn1     = r_res_q.ent.p1.ppn;
   assign bus.r_plv1     = r_res_q.ent.p1.plv;
   assign bus.r_mat1     = r_res_q.ent.p1.mat;
   assign bus.r_d1       = r_res_q.ent.p1.d;
   assign bus.r_v1       = r_res_q.ent.p1.v;

   assign bus.w_ready    = ready_q;
   assign bus.fill_index = fill_index_q;
   assign bus.inv_ready  = ready_q;
   assign bus.inv_done   = inv_done_q;
   assign bus.inv_err    = inv_err_q;
endmodule

// File: tb/tb_tlb_sweep.sv
// tb_tlb_sweep: randomized self-checking bench for tlb_sweep against a table-level model.
module tb_tlb_sweep;
   localparam int unsigned N = 16;

   typedef struct packed {
      logic            e;
      logic [18:0]     vppn;
      logic [5:0]      ps;
      logic [9:0]      asid;
      logic            g;
      logic [1:0][19:0] ppn;
      logic [1:0][1:0] plv;
      logic [1:0][1:0] mat;
      logic [1:0]      d;
      logic [1:0]      v;
   } ment_t;

   logic clk = 1'b0;
   logic resetn;
   int   n_cmp = 0;
   int   n_bad = 0;
   ment_t m [N];
   logic [15:0] m_lfsr;

   always #5 clk = ~clk;

   tlb_sweep_if #(.TLBNUM(N), .ASID_W(10)) bus ();

`ifdef TLB_PERF_EN
   logic [31:0] perf_hit;
   logic [31:0] perf_miss;
   tlb_sweep #(.TLBNUM(N), .ASID_W(10)) dut (
      .clk(clk), .resetn(resetn), .bus(bus), .perf_hit(perf_hit), .perf_miss(perf_miss)
   );
`else
   tlb_sweep #(.TLBNUM(N), .ASID_W(10)) dut (.clk(clk), .resetn(resetn), .bus(bus));
`endif

   // Reference LFSR: 16-bit Fibonacci x^16+x^14+x^13+x^11+1, right-shifting, one step per clock.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) m_lfsr <= 16'hACE1;
      else m_lfsr <= (m_lfsr >> 1) |
                     (16'(m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5]) << 15);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic mva(logic [18:0] ev, logic [5:0] ps, logic [18:0] v);
      if (ps == 6'd21) return ev[18:9] == v[18:9];
      return ev == v;
   endfunction

   function automatic int m_search(logic [18:0] vp, logic [9:0] as);
      for (int i = 0; i < int'(N); i++)
         if (m[i].e && (m[i].g || m[i].asid == as) && mva(m[i].vppn, m[i].ps, vp)) return i;
      return -1;
   endfunction

   function automatic logic [36:0] s_exp(logic [18:0] vp, logic b12, logic [9:0] as);
      int h;
      logic o;
      h = m_search(vp, as);
      if (h < 0) return '0;
      o = (m[h].ps == 6'd21) ? vp[8] : b12;
      return {1'b1, 4'(h), m[h].ppn[o], m[h].ps, m[h].plv[o], m[h].mat[o], m[h].d[o], m[h].v[o]};
   endfunction

   function automatic logic [36:0] s_obs();
      return {bus.s_found, bus.s_index, bus.s_ppn, bus.s_ps, bus.s_plv, bus.s_mat, bus.s_d,
              bus.s_v};
   endfunction

   function automatic logic [88:0] r_exp(ment_t x);
      return {x.e, x.vppn, x.ps, x.asid, x.g, x.ppn[0], x.plv[0], x.mat[0], x.d[0], x.v[0],
              x.ppn[1], x.plv[1], x.mat[1], x.d[1], x.v[1]};
   endfunction

   function automatic logic [88:0] r_obs();
      return {bus.r_e, bus.r_vppn, bus.r_ps, bus.r_asid, bus.r_g, bus.r_ppn0, bus.r_plv0,
              bus.r_mat0, bus.r_d0, bus.r_v0, bus.r_ppn1, bus.r_plv1, bus.r_mat1, bus.r_d1,
              bus.r_v1};
   endfunction

   function automatic logic should_clear(int op, ment_t x, logic [9:0] as, logic [18:0] vp);
      logic am, vm;
      am = (x.asid == as);
      vm = mva(x.vppn, x.ps, vp);
      case (op)
         0, 1:    return 1'b1;
         2:       return x.g;
         3:       return !x.g;
         4:       return !x.g && am;
         5:       return !x.g && am && vm;
         6:       return (x.g || am) && vm;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [18:0] rand_vppn();
      logic [18:0] v;
      v = '0;
      v[10:9] = 2'($urandom_range(0, 3));
      v[8]    = 1'($urandom_range(0, 1));
      v[1:0]  = 2'($urandom_range(0, 3));
      return v;
   endfunction

   function automatic ment_t rand_ent();
      ment_t x;
      x.e    = ($urandom_range(0, 4) != 0);
      x.ps   = ($urandom_range(0, 1) != 0) ? 6'd21 : 6'd12;
      x.vppn = rand_vppn();
      x.asid = 10'($urandom_range(0, 3));
      x.g    = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 2; k++) begin
         x.ppn[k] = 20'($urandom);
         x.plv[k] = 2'($urandom);
         x.mat[k] = 2'($urandom);
         x.d[k]   = 1'($urandom);
         x.v[k]   = 1'($urandom);
      end
      return x;
   endfunction

   function automatic logic [3:0] m_target(logic fill, logic [3:0] idx);
      if (!fill) return idx;
      for (int i = 0; i < int'(N); i++) if (!m[i].e) return 4'(i);
      return m_lfsr[3:0];
   endfunction

   task automatic idle_inputs();
      bus.s_req = 0; bus.s_vppn = '0; bus.s_va_bit12 = 0; bus.s_asid = '0;
      bus.r_req = 0; bus.r_index = '0;
      bus.we = 0; bus.w_fill = 0; bus.w_index = '0; bus.w_e = 0; bus.w_vppn = '0;
      bus.w_ps = '0; bus.w_asid = '0; bus.w_g = 0;
      bus.w_ppn0 = '0; bus.w_plv0 = '0; bus.w_mat0 = '0; bus.w_d0 = 0; bus.w_v0 = 0;
      bus.w_ppn1 = '0; bus.w_plv1 = '0; bus.w_mat1 = '0; bus.w_d1 = 0; bus.w_v1 = 0;
      bus.inv_valid = 0; bus.inv_op = '0; bus.inv_asid = '0; bus.inv_vppn = '0;
   endtask

   task automatic set_w(input ment_t x, input logic fill, input logic [3:0] idx);
      bus.we = 1; bus.w_fill = fill; bus.w_index = idx; bus.w_e = x.e; bus.w_vppn = x.vppn;
      bus.w_ps = x.ps; bus.w_asid = x.asid; bus.w_g = x.g;
      bus.w_ppn0 = x.ppn[0]; bus.w_plv0 = x.plv[0]; bus.w_mat0 = x.mat[0];
      bus.w_d0 = x.d[0]; bus.w_v0 = x.v[0];
      bus.w_ppn1 = x.ppn[1]; bus.w_plv1 = x.plv[1]; bus.w_mat1 = x.mat[1];
      bus.w_d1 = x.d[1]; bus.w_v1 = x.v[1];
   endtask

   // Write one entry in IDLE and mirror it into the model; returns the model's target index.
   task automatic do_write(input ment_t x, input logic fill, input logic [3:0] idx,
                           output logic [3:0] tgt);
      tgt = m_target(fill, idx);
      set_w(x, fill, idx);
      tick();
      bus.we = 0;
      m[tgt] = x;
   endtask

   task automatic do_search(input logic [18:0] vp, input logic b12, input logic [9:0] as);
      bus.s_req = 1; bus.s_vppn = vp; bus.s_va_bit12 = b12; bus.s_asid = as;
      tick();
      bus.s_req = 0;
   endtask

   task automatic do_read(input logic [3:0] idx);
      bus.r_req = 1; bus.r_index = idx;
      tick();
      bus.r_req = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      resetn = 0;
      tick();
      for (int i = 0; i < int'(N); i++) m[i].e = 1'b0;
      resetn = 1;
      tick();
   endtask

   // Issue an INVTLB and wait (bounded) for inv_done; cycle 1 is the first cycle after acceptance.
   task automatic run_inv(input int op, input logic [9:0] as, input logic [18:0] vp,
                          output int done_c);
      bus.inv_valid = 1; bus.inv_op = 5'(op); bus.inv_asid = as; bus.inv_vppn = vp;
      tick();
      bus.inv_valid = 0;
      done_c = -1;
      for (int c = 1; c <= 40; c++) begin
         if (bus.inv_done === 1'b1) begin
            done_c = c;
            break;
         end
         tick();
      end
      for (int i = 0; i < int'(N); i++) if (should_clear(op, m[i], as, vp)) m[i].e = 1'b0;
   endtask

   function automatic ment_t spec_ent(logic [18:0] vp, logic [5:0] ps, logic [9:0] as, logic g,
                                      logic [19:0] p0, logic [19:0] p1);
      ment_t x;
      x = '0;
      x.e = 1; x.vppn = vp; x.ps = ps; x.asid = as; x.g = g;
      x.ppn[0] = p0; x.ppn[1] = p1; x.v = 2'b11;
      return x;
   endfunction

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({bus.s_resp, bus.s_found, bus.r_resp, bus.inv_done, bus.inv_err, bus.w_ready,
           bus.inv_ready, bus.fill_index} !== {7'b0000011, 4'd0}) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b", {bus.s_resp, bus.s_found, bus.r_resp,
                  bus.inv_done, bus.inv_err, bus.w_ready, bus.inv_ready, bus.fill_index});
      end
      do_search(19'h12345, 1'b0, 10'd1);
      n_cmp++;
      if ({bus.s_resp, s_obs()} !== {1'b1, 37'd0}) begin
         n_bad++;
         $display("FAIL reset_search_miss: got %h expected %h", {bus.s_resp, s_obs()},
                  {1'b1, 37'd0});
      end
   endtask

   task automatic test_search_write();
      logic [3:0] t;
      do_write(spec_ent(19'h12345, 6'd12, 10'd1, 1'b0, 20'hAAAAA, 20'hBBBBB), 1'b0, 4'd3, t);
      do_search(19'h12345, 1'b1, 10'd1);
      n_cmp++;
      if ({bus.s_found, bus.s_index, bus.s_ppn} !== {1'b1, 4'd3, 20'hBBBBB}) begin
         n_bad++;
         $display("FAIL search_idx3_odd: got %h expected %h", {bus.s_found, bus.s_index,
                  bus.s_ppn}, {1'b1, 4'd3, 20'hBBBBB});
      end
      do_search(19'h12345, 1'b1, 10'd2);
      n_cmp++;
      if (bus.s_found !== 1'b0) begin
         n_bad++;
         $display("FAIL search_asid_miss: got %b expected 0", bus.s_found);
      end
      do_write(spec_ent(19'h40000, 6'd21, 10'd0, 1'b1, 20'hDDDDD, 20'hCCCCC), 1'b0, 4'd5, t);
      do_search(19'h401FF, 1'b0, 10'd7);
      n_cmp++;
      if ({bus.s_found, bus.s_index, bus.s_ppn, bus.s_ps} !==
          {1'b1, 4'd5, 20'hCCCCC, 6'd21}) begin
         n_bad++;
         $display("FAIL search_4m_global: got %h expected %h", {bus.s_found, bus.s_index,
                  bus.s_ppn, bus.s_ps}, {1'b1, 4'd5, 20'hCCCCC, 6'd21});
      end
   endtask

   task automatic test_fill();
      logic [3:0] t;
      logic [3:0] want;
      ment_t x;
      do_reset();
      for (int i = 0; i < int'(N); i++) begin
         x = rand_ent();
         x.e = 1'b1;
         do_write(x, 1'b1, 4'd0, t);
         n_cmp++;
         if (bus.fill_index !== 4'(i)) begin
            n_bad++;
            $display("FAIL fill_free_%0d: got %0d expected %0d", i, bus.fill_index, i);
         end
      end
      want = m_lfsr[3:0];
      x = rand_ent();
      do_write(x, 1'b1, 4'd0, t);
      n_cmp++;
      if (bus.fill_index !== want) begin
         n_bad++;
         $display("FAIL fill_lfsr_victim: got %0d expected %0d", bus.fill_index, want);
      end
   endtask

   task automatic test_random();
      logic [3:0]  t;
      logic [36:0] es;
      logic [88:0] er;
      logic        sq, rq, wq;
      logic [18:0] vp;
      logic        b12;
      logic [9:0]  as;
      logic [3:0]  ri;
      ment_t       x;
      do_reset();
      for (int i = 0; i < int'(N); i++) do_write(rand_ent(), 1'b0, 4'(i), t);
      es = s_obs();
      er = r_obs();
      for (int it = 0; it < 300; it++) begin
         sq = ($urandom_range(0, 9) < 6);
         rq = ($urandom_range(0, 1) != 0);
         wq = ($urandom_range(0, 1) != 0);
         vp = rand_vppn();
         b12 = 1'($urandom);
         as = 10'($urandom_range(0, 3));
         ri = 4'($urandom);
         x = rand_ent();
         // search and read see the table as it was before this cycle's write
         if (sq) es = s_exp(vp, b12, as);
         if (rq) er = r_exp(m[ri]);
         bus.s_req = sq; bus.s_vppn = vp; bus.s_va_bit12 = b12; bus.s_asid = as;
         bus.r_req = rq; bus.r_index = ri;
         if (wq) begin
            t = m_target($urandom_range(0, 3) == 0, ri ^ 4'hA);
            set_w(x, t != (ri ^ 4'hA) || bus.w_fill, ri ^ 4'hA);
            bus.w_fill = (t != (ri ^ 4'hA)) ? 1'b1 : 1'b0;
         end
         tick();
         idle_inputs();
         if (wq) m[t] = x;
         n_cmp++;
         if ({bus.s_resp, bus.r_resp, s_obs()} !== {sq, rq, es}) begin
            n_bad++;
            $display("FAIL rand_search_%0d: got %h expected %h", it,
                     {bus.s_resp, bus.r_resp, s_obs()}, {sq, rq, es});
         end
         n_cmp++;
         if (r_obs() !== er) begin
            n_bad++;
            $display("FAIL rand_read_%0d: got %h expected %h", it, r_obs(), er);
         end
      end
   endtask

   task automatic test_inv_sweep();
      logic [3:0] t;
      int rdy_low, done_c;
      do_reset();
      do_write(spec_ent(19'h12345, 6'd12, 10'd1, 1'b0, 20'hAAAAA, 20'hBBBBB), 1'b0, 4'd3, t);
      do_write(spec_ent(19'h40000, 6'd21, 10'd0, 1'b1, 20'hDDDDD, 20'hCCCCC), 1'b0, 4'd5, t);
      bus.inv_valid = 1; bus.inv_op = 5'd4; bus.inv_asid = 10'd1; bus.inv_vppn = '0;
      tick();
      bus.inv_valid = 0;
      rdy_low = 0;
      done_c = -1;
      for (int c = 1; c <= 40; c++) begin
         if (c <= 16 && bus.inv_ready === 1'b0 && bus.w_ready === 1'b0) rdy_low++;
         if (bus.inv_done === 1'b1) begin
            done_c = c;
            break;
         end
         if (c == 2) set_w(spec_ent(19'h00555, 6'd12, 10'd1, 1'b0, 20'h1, 20'h2), 1'b0, 4'd0);
         else bus.we = 0;
         tick();
      end
      bus.we = 0;
      for (int i = 0; i < int'(N); i++)
         if (should_clear(4, m[i], 10'd1, 19'd0)) m[i].e = 1'b0;
      n_cmp++;
      if (rdy_low !== 16) begin
         n_bad++;
         $display("FAIL inv_ready_low: got %0d cycles expected 16", rdy_low);
      end
      n_cmp++;
      if (done_c !== int'(N) + 1) begin
         n_bad++;
         $display("FAIL inv_done_cycle: got %0d expected %0d", done_c, N + 1);
      end
      tick();
      n_cmp++;
      if ({bus.inv_ready, bus.inv_done} !== 2'b10) begin
         n_bad++;
         $display("FAIL inv_back_idle: got %b expected 10", {bus.inv_ready, bus.inv_done});
      end
      do_read(4'd3);
      n_cmp++;
      if (bus.r_e !== 1'b0) begin
         n_bad++;
         $display("FAIL inv_op4_idx3: got %b expected 0", bus.r_e);
      end
      do_read(4'd5);
      n_cmp++;
      if (bus.r_e !== 1'b1) begin
         n_bad++;
         $display("FAIL inv_op4_idx5: got %b expected 1", bus.r_e);
      end
      do_read(4'd0);
      n_cmp++;
      if (bus.r_e !== 1'b0) begin
         n_bad++;
         $display("FAIL inv_write_ignored: got %b expected 0", bus.r_e);
      end
   endtask

   task automatic test_inv_random();
      logic [3:0] t;
      int op, done_c;
      logic [9:0] as;
      logic [18:0] vp;
      for (int rnd = 0; rnd < 7; rnd++) begin
         for (int i = 0; i < int'(N); i++) do_write(rand_ent(), 1'b0, 4'(i), t);
         op = rnd;
         as = 10'($urandom_range(0, 3));
         vp = rand_vppn();
         run_inv(op, as, vp, done_c);
         n_cmp++;
         if (done_c !== int'(N) + 1) begin
            n_bad++;
            $display("FAIL inv_rand_done_op%0d: got %0d expected %0d", op, done_c, N + 1);
         end
         tick();
         for (int i = 0; i < int'(N); i++) begin
            do_read(4'(i));
            n_cmp++;
            if (r_obs() !== r_exp(m[i])) begin
               n_bad++;
               $display("FAIL inv_rand_op%0d_idx%0d: got %h expected %h", op, i, r_obs(),
                        r_exp(m[i]));
            end
         end
      end
   endtask

   task automatic test_inv_err();
      logic [3:0] t;
      ment_t x;
      bus.inv_valid = 1; bus.inv_op = 5'd9; bus.inv_asid = '0; bus.inv_vppn = '0;
      tick();
      bus.inv_valid = 0;
      n_cmp++;
      if ({bus.inv_err, bus.inv_ready} !== 2'b11) begin
         n_bad++;
         $display("FAIL inv_err_pulse: got %b expected 11", {bus.inv_err, bus.inv_ready});
      end
      tick();
      n_cmp++;
      if ({bus.inv_err, bus.inv_done} !== 2'b00) begin
         n_bad++;
         $display("FAIL inv_err_single: got %b expected 00", {bus.inv_err, bus.inv_done});
      end
      for (int i = 0; i < int'(N); i++) begin
         do_read(4'(i));
         n_cmp++;
         if (bus.r_e !== m[i].e) begin
            n_bad++;
            $display("FAIL inv_err_state_idx%0d: got %b expected %b", i, bus.r_e, m[i].e);
         end
      end
      // write and INVTLB together: the write is taken, the INVTLB dropped
      x = rand_ent();
      x.e = 1'b1;
      bus.inv_valid = 1; bus.inv_op = 5'd0;
      do_write(x, 1'b0, 4'd7, t);
      bus.inv_valid = 0;
      n_cmp++;
      if (bus.inv_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL write_over_inv_ready: got %b expected 1", bus.inv_ready);
      end
      do_read(4'd7);
      n_cmp++;
      if (r_obs() !== r_exp(m[7])) begin
         n_bad++;
         $display("FAIL write_over_inv_data: got %h expected %h", r_obs(), r_exp(m[7]));
      end
   endtask

   task automatic test_reset_mid_sweep();
      int dones;
      bus.inv_valid = 1; bus.inv_op = 5'd3; bus.inv_asid = '0; bus.inv_vppn = '0;
      tick();
      bus.inv_valid = 0;
      repeat (5) tick();
      resetn = 0;
      #1;
      n_cmp++;
      if ({bus.inv_ready, bus.w_ready, bus.inv_done} !== 3'b110) begin
         n_bad++;
         $display("FAIL reset_mid_sweep_idle: got %b expected 110",
                  {bus.inv_ready, bus.w_ready, bus.inv_done});
      end
      for (int i = 0; i < int'(N); i++) m[i].e = 1'b0;
      tick();
      resetn = 1;
      dones = 0;
      for (int c = 0; c < 25; c++) begin
         if (bus.inv_done === 1'b1) dones++;
         tick();
      end
      n_cmp++;
      if (dones !== 0) begin
         n_bad++;
         $display("FAIL reset_mid_sweep_done: got %0d pulses expected 0", dones);
      end
      for (int i = 0; i < int'(N); i++) begin
         do_read(4'(i));
         n_cmp++;
         if (bus.r_e !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_sweep_e%0d: got %b expected 0", i, bus.r_e);
         end
      end
   endtask

   initial begin
      resetn = 0;
      idle_inputs();
      test_reset();
      test_search_write();
      test_fill();
      test_random();
      test_inv_sweep();
      test_inv_random();
      test_inv_err();
      test_reset_mid_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/tlb_sweep.md
Name: tlb_sweep

Overview:
Parametrised successor TLB for the LoongArch-style MMU: fully associative, with a registered search port, a registered read port, a write/fill port, and a multi-cycle INVTLB sweep engine. Fill picks a free entry first and otherwise an LFSR victim. Sits between the fetch/LSU address-translation stage and the CSR/TLB-instruction unit.

Parameters:
TLBNUM, 16, entry count; power of two, 4..64; IDXW = $clog2(TLBNUM)
ASID_W, 10, ASID width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
s_req  in  1  search request
s_vppn  in  19  search VA[31:13]
s_va_bit12  in  1  search VA[12]
s_asid  in  ASID_W  search ASID
s_resp  out  1  search result valid, 1 cycle after s_req
s_found / s_index / s_ppn / s_ps / s_plv / s_mat / s_d / s_v  out  1/IDXW/20/6/2/2/1/1  registered search result
r_req  in  1  read request
r_index  in  IDXW  read index
r_resp  out  1  read data valid, 1 cycle after r_req
r_e / r_vppn / r_ps / r_asid / r_g  out  1/19/6/ASID_W/1  registered entry fields
r_ppn0 / r_plv0 / r_mat0 / r_d0 / r_v0, r_ppn1 / r_plv1 / r_mat1 / r_d1 / r_v1  out  20/2/2/1/1 each  registered page fields
we  in  1  write request
w_fill  in  1  1: engine selects the index; 0: use w_index
w_index  in  IDXW  explicit write index
w_e / w_vppn / w_ps / w_asid / w_g / w_ppn0..w_v1  in  as r_*  write data
w_ready  out  1  high in IDLE; writes accepted only when we & w_ready
fill_index  out  IDXW  index used by the last accepted fill; registered
inv_valid  in  1  INVTLB request
inv_op  in  5  INVTLB op
inv_asid  in  ASID_W  INVTLB ASID
inv_vppn  in  19  INVTLB VA[31:13]
inv_ready  out  1  high in IDLE
inv_done  out  1  1-cycle pulse at the end of a sweep
inv_err  out  1  1-cycle pulse for an illegal op, 1 cycle after acceptance

Behaviour:
- Reset (asynchronous, resetn=0): all tlb_e=0; FSM=IDLE; LFSR=16'hACE1; every output 0 except w_ready=inv_ready=1. Entry payload is not reset.
- Match for entry i: e & (g | asid==s_asid) & (ps==21 ? vppn[18:9]==s_vppn[18:9] : vppn==s_vppn). Only ps 12 and 21 are legal.
- Page select: odd = (ps==21) ? s_vppn[8] : s_va_bit12. Odd selects the *1 fields, even selects the *0 fields.
- Multiple hits: the lowest index wins.
- Search latency 1: result registered on s_req. On a miss, s_found=0 and the other s_* outputs are 0. s_resp follows s_req delayed by one cycle. With s_req=0, outputs hold.
- Read latency 1: on r_req, the fields of r_index are registered. Outputs hold otherwise.
- Write in IDLE, committed at the clock edge.
  - w_fill=0: target index = w_index.
  - w_fill=1: target index = lowest index with e=0; if none, LFSR[IDXW-1:0]. fill_index is updated with it.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle.
- Same-cycle write and search/read: search/read observe the pre-write contents.
- Same cycle we and inv_valid in IDLE: the write is accepted; the INVTLB is ignored. The requester must hold inv_valid until inv_ready.
- FSM:
  - IDLE: on inv_valid with op 0..6, latch op/asid/vppn, set ptr=0, go to SWEEP, drop w_ready/inv_ready. On ops 7..31, pulse inv_err and stay in IDLE.
  - SWEEP: each cycle evaluate entry ptr and clear e if it qualifies, then ptr++. After ptr==TLBNUM-1, go to DONE.
  - DONE: pulse inv_done for 1 cycle, then IDLE. Total from acceptance to done = TLBNUM+1 cycles.
- Clear conditions:
  - op0, op1: all entries.
  - op2: g=1.
  - op3: g=0.
  - op4: g=0 & asid match.
  - op5: g=0 & asid match & va match.
  - op6: (g=1 | asid match) & va match.
  - va match uses the same ps-dependent rule as search.
- Searches and reads remain serviced during SWEEP and see the partially swept state.
- resetn asserted mid-sweep: immediate IDLE, all e=0, no inv_done.

Optional Feature:
TLB_PERF_EN
- Defined: adds outputs perf_hit (32) and perf_miss (32). Each s_req increments one of them, saturating at 32'hFFFFFFFF; both are cleared by reset.
- Undefined: these ports and counters do not exist; no other behaviour changes.

Test Plan:
- Reset, then search vppn=0x12345 asid=1 -> s_resp=1 next cycle, s_found=0, w_ready=inv_ready=1.
- Write idx3: vppn=0x12345, ps=12, asid=1, g=0, ppn0=0xAAAAA, ppn1=0xBBBBB, v0=v1=1. Search with va_bit12=1 -> found, index 3, ppn 0xBBBBB. Same search with asid=2 -> miss.
- Write idx5: ps=21, vppn=0x40000, g=1. Search vppn=0x401FF asid=7 -> found, index 5, odd page (vppn[8]=1).
- Fill 16 times with w_fill=1 after reset -> fill_index 0..15 in order. 17th fill -> fill_index = LFSR[3:0] sampled at acceptance.
- inv_op=4 inv_asid=1 with entries {3: asid1 g0, 5: g1} -> inv_ready low for 16 cycles, inv_done on cycle 17; entry 3 e=0, entry 5 e=1; we during sweep ignored.
- inv_op=9 -> inv_err pulse, no state change. Assert resetn during a sweep -> all e=0 and no inv_done.
